crono_countdown: RTL
====================

Name: crono_countdown

Overview:
- Run-time engine of the countdown timer (cronómetro).
- Takes the hour/minute/second values set by the user-adjust counters, loads them on request and decrements once per 1 Hz strobe.
- Raises a ring (alarm) output for a bounded time when the count reaches 00:00:00.
- Its outputs drive the display mux and the alarm/LED logic.

Parameters:
- HORA_MAX, 11, highest legal hour value; set values above it are clamped.
- MIN_MAX, 59, highest legal minute value; also the reload value for minutes on borrow.
- SEG_MAX, 59, highest legal second value; also the reload value for seconds on borrow.
- RING_TICKS, 10, number of tick_1hz strobes the ring output stays high in DONE.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- tick_1hz  in  1  one-clk-wide strobe, once per second.
- load  in  1  one-clk pulse; capture set_* into the count registers.
- start  in  1  one-clk pulse; begin or resume the countdown.
- stop  in  1  one-clk pulse; pause in RUN, acknowledge/silence in DONE.
- set_hora  in  4  hour value from the adjust counter.
- set_min  in  6  minute value from the adjust counter.
- set_seg  in  6  second value from the adjust counter.
- cnt_hora  out  4  current remaining hours, registered.
- cnt_min  out  6  current remaining minutes, registered.
- cnt_seg  out  6  current remaining seconds, registered.
- running  out  1  high while in RUN.
- ring  out  1  high while in DONE.

Behaviour:
- Reset: state IDLE; cnt_hora, cnt_min and cnt_seg = 0; running = 0; ring = 0; ring counter = 0. Reset applies on any clk edge with rst = 1, overriding all other inputs, including mid-RUN and mid-DONE.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered; every state or count change is visible the cycle after the triggering edge.
- Load clamping: each captured field = min(set_x, X_MAX).
- IDLE:
  - load: capture clamped values; stay IDLE.
  - start: go to RUN if the current count is not 00:00:00; otherwise ignore start and stay IDLE.
  - If load and start arrive in the same cycle, load wins and start is ignored.
  - tick and stop are ignored.
- RUN:
  - stop: go to PAUSE. If tick arrives in the same cycle, stop has priority and no decrement happens.
  - tick without stop, borrow chain:
    - seg > 0: seg - 1.
    - seg = 0 and min > 0: min - 1, seg = SEG_MAX.
    - seg = 0, min = 0, hora > 0: hora - 1, min = MIN_MAX, seg = SEG_MAX.
  - If the decrement result is 00:00:00, go to DONE on the same edge and clear the ring counter.
  - load and start are ignored.
- PAUSE:
  - start: go to RUN.
  - load: capture clamped values and go to IDLE.
  - If start and load arrive together, load wins.
  - stop and tick are ignored.
- DONE:
  - Counts hold at 0; ring = 1.
  - Each tick increments the ring counter. On the tick that makes it equal RING_TICKS, go to IDLE and clear ring.
  - stop: go to IDLE immediately; stop has priority over tick.
  - load and start are ignored.
- running = 1 only in RUN; ring = 1 only in DONE; both never high together.
- Counts never underflow or exceed the *_MAX parameters.
- The ring counter is wide enough to hold RING_TICKS.

Test Plan:
- Reset then load with set_hora = 0, set_min = 1, set_seg = 2, start, then 62 ticks: counts go 0:01:02 -> 0:01:01 -> 0:01:00 -> 0:00:59 … 0:00:01. The DONE transition comes on tick 62 with ring = 1 and running = 0.
- Load 1:00:00, start, one tick -> 0:59:59. Load set_hora = 15, set_min = 63, set_seg = 60 in IDLE -> counts 11:59:59 (clamped).
- RUN at 0:00:05, stop and tick in the same cycle -> PAUSE, count stays 0:00:05. Three further ticks -> no change. start -> RUN, next tick -> 0:00:04.
- Load 0:00:00, start -> stays IDLE, running = 0, ring = 0. load and start in the same cycle with 0:00:03 -> IDLE holding 0:00:03.
- DONE with RING_TICKS = 10: 9 ticks -> ring still 1, 10th tick -> IDLE, ring = 0. Separate run: stop 2 ticks into DONE -> ring = 0 next cycle.
- rst asserted mid-RUN at 0:30:10 -> next cycle all counts 0, state IDLE, running = 0. A tick asserted together with rst has no effect.

Source files
------------

// File: rtl/crono_countdown.sv
// crono_countdown: run-time engine of the countdown timer.
// Loads clamped hh:mm:ss from the adjust counters, decrements once per tick_1hz
// while running, and rings for RING_TICKS seconds when the count hits 00:00:00.
// Ports: clk/rst (sync, active-high); tick_1hz, load, start, stop strobes;
//        set_hora/set_min/set_seg in; cnt_* counts, running, ring out (all registered).
module crono_countdown #(
  parameter int HORA_MAX   = 11,
  parameter int MIN_MAX    = 59,
  parameter int SEG_MAX    = 59,
  parameter int RING_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] set_hora,
  input  logic [5:0] set_min,
  input  logic [5:0] set_seg,
  output logic [3:0] cnt_hora,
  output logic [5:0] cnt_min,
  output logic [5:0] cnt_seg,
  output logic       running,
  output logic       ring
);

  localparam int RW = $clog2(RING_TICKS + 1);

  localparam logic [3:0]    HORA_LIM  = 4'(HORA_MAX);
  localparam logic [5:0]    MIN_LIM   = 6'(MIN_MAX);
  localparam logic [5:0]    SEG_LIM   = 6'(SEG_MAX);
  // Ring counter value on which the next tick ends the alarm.
  localparam logic [RW-1:0] RING_LAST = RW'(RING_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    hora_q, hora_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    seg_q, seg_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic          running_q, running_d;
  logic          ring_q, ring_d;

  logic [3:0] hora_clamp;
  logic [5:0] min_clamp;
  logic [5:0] seg_clamp;
  logic       count_zero;
  logic       last_second;

  assign hora_clamp  = (set_hora > HORA_LIM) ? HORA_LIM : set_hora;
  assign min_clamp   = (set_min  > MIN_LIM)  ? MIN_LIM  : set_min;
  assign seg_clamp   = (set_seg  > SEG_LIM)  ? SEG_LIM  : set_seg;
  assign count_zero  = (hora_q == 4'd0) && (min_q == 6'd0) && (seg_q == 6'd0);
  // The only decrement that lands on 00:00:00 is from 00:00:01.
  assign last_second = (hora_q == 4'd0) && (min_q == 6'd0) && (seg_q == 6'd1);

  // State and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hora_q     <= 4'd0;
      min_q      <= 6'd0;
      seg_q      <= 6'd0;
      ring_cnt_q <= '0;
      running_q  <= 1'b0;
      ring_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hora_q     <= hora_d;
      min_q      <= min_d;
      seg_q      <= seg_d;
      ring_cnt_q <= ring_cnt_d;
      running_q  <= running_d;
      ring_q     <= ring_d;
    end
  end

  // Next-state and count logic
  always_comb begin
    state_d    = state_q;
    hora_d     = hora_q;
    min_d      = min_q;
    seg_d      = seg_q;
    ring_cnt_d = ring_cnt_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          hora_d = hora_clamp;
          min_d  = min_clamp;
          seg_d  = seg_clamp;
        end else if (start && !count_zero) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = PAUSE;
        end else if (tick_1hz) begin
          if (seg_q != 6'd0) begin
            seg_d = seg_q - 6'd1;
          end else if (min_q != 6'd0) begin
            min_d = min_q - 6'd1;
            seg_d = SEG_LIM;
          end else if (hora_q != 4'd0) begin
            hora_d = hora_q - 4'd1;
            min_d  = MIN_LIM;
            seg_d  = SEG_LIM;
          end
          if (last_second) begin
            state_d    = DONE;
            ring_cnt_d = '0;
          end
        end
      end
      PAUSE: begin
        if (load) begin
          hora_d  = hora_clamp;
          min_d   = min_clamp;
          seg_d   = seg_clamp;
          state_d = IDLE;
        end else if (start) begin
          state_d = RUN;
        end
      end
      DONE: begin
        hora_d = 4'd0;
        min_d  = 6'd0;
        seg_d  = 6'd0;
        if (stop) begin
          state_d    = IDLE;
          ring_cnt_d = '0;
        end else if (tick_1hz) begin
          if (ring_cnt_q == RING_LAST) begin
            state_d    = IDLE;
            ring_cnt_d = '0;
          end else begin
            ring_cnt_d = ring_cnt_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the next state so they register alongside it
  always_comb begin
    running_d = (state_d == RUN);
    ring_d    = (state_d == DONE);
  end

  assign cnt_hora = hora_q;
  assign cnt_min  = min_q;
  assign cnt_seg  = seg_q;
  assign running  = running_q;
  assign ring     = ring_q;

endmodule
